fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the image-filter processor.
- Owns the program counter and drives the instruction memory address (DIR); registers the returned word (DO) into the IF/ID stage register.
- Handles start, stall, branch redirect with bubble insertion, and halt detection. A halt is the branch-to-self idiom. After a halt the block drains the pipeline with NOPs and then raises DONE.

Parameters:
- RESET_PC, 32'h00000000, PC loaded at reset and on every START.
- NOP_WORD, 32'h0F000000, word injected as a bubble and shown in IF_INSTR while not valid.
- HALT_WORD, 32'hFFFFFFFE-offset branch encoding 32'h9EFFFFFE, fetched word that triggers halt.
- DRAIN_CYCLES, 4, number of NOP cycles issued after the halt word before DONE (range 1..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle pulse; begins fetch from RESET_PC.
- STALL  in  1  hold PC and IF register (hazard from decode/execute).
- BR_TAKEN  in  1  redirect request from execute.
- BR_TARGET  in  32  redirect byte address.
- IMEM_ADDR  out  32  to instruction memory DIR; always equals PC (combinational from PC register).
- IMEM_DATA  in  32  from instruction memory DO; combinational, same cycle.
- IF_INSTR  out  32  registered instruction to decode.
- IF_PC  out  32  registered address of IF_INSTR.
- IF_VALID  out  1  IF_INSTR is a real fetched instruction.
- BUSY  out  1  high in RUN or DRAIN.
- DONE  out  1  high in HALTED.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, PC=RESET_PC, IF_INSTR=NOP_WORD, IF_PC=0, IF_VALID=0, drain counter=0, BUSY=0, DONE=0. Reset mid-run abandons all state immediately.
- PC arithmetic: PC+4 modulo 2^32, so 32'hFFFFFFFC wraps to 0. BR_TARGET[1:0] is forced to 2'b00 when loaded.
- IDLE:
  - IF outputs hold NOP / invalid.
  - START -> RUN, PC=RESET_PC. The first valid IF_INSTR appears the cycle after the first RUN edge (1-cycle fetch latency).
- RUN, priority order per edge:
  1. BR_TAKEN: PC<=BR_TARGET; IF_INSTR<=NOP_WORD; IF_VALID<=0. This is one bubble, and it wins over STALL.
  2. STALL: PC, IF_INSTR, IF_PC and IF_VALID all hold.
  3. Otherwise: IF_INSTR<=IMEM_DATA, IF_PC<=PC, IF_VALID<=1, PC<=PC+4.
  - If the word captured in case 3 equals HALT_WORD, it is passed through as valid, PC holds, counter<=0, and the state goes to DRAIN.
- DRAIN:
  - Each non-stalled edge: IF_INSTR<=NOP_WORD, IF_VALID<=0, counter++. PC holds.
  - When counter reaches DRAIN_CYCLES-1 on an advancing edge -> HALTED.
  - BR_TAKEN during DRAIN (an older in-flight branch) cancels the drain: PC<=BR_TARGET, bubble, state RUN.
  - STALL holds the counter.
- HALTED: DONE=1, BUSY=0, IF outputs NOP / invalid. START restarts exactly as from IDLE. BR_TAKEN and STALL are ignored.
- START in RUN or DRAIN is ignored. BR_TAKEN and STALL in IDLE are ignored.
- BUSY and DONE are decoded from the state register (glitch-free registered state).

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, RUN, DRAIN, HALTED};
  - NOP_WORD and HALT_WORD constants, which are also used by decode and by the instruction-memory image.
- No sub-module. The PC register, IF register and drain counter sit in one block of roughly 150–200 lines.

Test Plan:
- Reset then START, memory returning DIR-based words, no stall -> IMEM_ADDR goes 0,4,8,C; IF_PC lags by one cycle; IF_VALID=1 from the second RUN edge.
- STALL high for 3 cycles at PC=0x10 -> IMEM_ADDR stays 0x10, IF_INSTR frozen, then resumes at 0x14.
- BR_TAKEN with target 0x86 at PC=0x20, STALL also high -> next PC=0x84, exactly one IF_VALID=0 bubble carrying 0x0F000000.
- Memory returns 0x9EFFFFFE at 0x90 -> halt word passed through valid, then 4 NOP cycles, then DONE=1, BUSY=0. A further START restarts at 0x00.
- BR_TAKEN to 0x40 in the 2nd DRAIN cycle -> back to RUN, PC=0x40, DONE never asserts.
- RST_N pulsed low mid-RUN at PC=0x2C -> outputs return to reset values asynchronously. PC is 0 and the block stays in IDLE until START. PC wrap check: run from 0xFFFFFFF8 -> IMEM_ADDR goes 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states and the special instruction
// words that decode and the instruction-memory image also rely on.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    // Bubble word; decode treats it as a no-op.
    localparam logic [31:0] NOP_WORD  = 32'h0F00_0000;
    // Branch-to-self encoding; seeing it fetched means the program is done.
    localparam logic [31:0] HALT_WORD = 32'h9EFF_FFFE;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory
// address and registers the returned word into the IF/ID stage register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; IF stage shows NOP / invalid
// ST_RUN    | fetching; branch redirect beats stall, stall beats advance
// ST_DRAIN  | halt word seen; issuing NOP bubbles until the count expires
// ST_HALTED | program finished; done raised, waiting for a new start
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        if_valid_o,
    output logic        busy_o,
    output logic        done_o
);

    // DRAIN_CYCLES is limited to 1..15, so four bits hold the drain count.
    localparam int unsigned    CNT_W      = 4;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ifpc_q, ifpc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, PC, IF/ID register and drain counter; reset abandons everything.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            ifpc_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: everything holds unless the current state says otherwise.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                // Branch and stall are meaningless here and are ignored.
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                if (br_taken_i) begin
                    pc_d    = word_align(br_target_i);
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    instr_d = imem_data_i;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    if (imem_data_i == HALT_WORD) begin
                        // Halt word still goes to decode; PC parks on it.
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            ST_DRAIN: begin
                if (br_taken_i) begin
                    // An older branch still in flight overrides the halt.
                    state_d = ST_RUN;
                    pc_d    = word_align(br_target_i);
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = ST_HALTED;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr_o = pc_q;
    assign if_instr_o  = instr_q;
    assign if_pc_o     = ifpc_q;
    assign if_valid_o  = valid_q;
    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver steps a behavioural model
// alongside the DUT and queues the expected outputs; a monitor compares them.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP  = 32'h0F00_0000;
    localparam logic [31:0] HALT = 32'h9EFF_FFFE;
    localparam int          DRAIN = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic        clk;
    logic        rst_n;
    logic        start, stall, br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] if_instr, if_pc;
    logic        if_valid, busy, done;
    logic [31:0] halt_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic        valid;
        logic        busy;
        logic        done;
    } snap_t;

    snap_t exp_q[$];

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ifpc;
    logic        m_valid;
    int          m_drained;

    fetch_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .stall_i     (stall),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .imem_addr_o (imem_addr),
        .imem_data_i (imem_data),
        .if_instr_o  (if_instr),
        .if_pc_o     (if_pc),
        .if_valid_o  (if_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: address-derived words, with the halt idiom at one address.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
        logic [31:0] w;
        if (a == h) return HALT;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    always_comb imem_data = mem_word(imem_addr, halt_addr);

    function automatic snap_t model_snap();
        snap_t s;
        s.addr  = m_pc;
        s.instr = m_instr;
        s.ifpc  = m_ifpc;
        s.valid = m_valid;
        s.busy  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
        s.done  = (m_mode == M_HALTED);
        return s;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_pc      = 32'h0;
        m_instr   = NOP;
        m_ifpc    = 32'h0;
        m_valid   = 1'b0;
        m_drained = 0;
    endtask

    // One clock edge of the fetch rules: start/branch/stall/advance/halt/drain.
    task automatic model_edge(input bit st, input bit sl, input bit br, input logic [31:0] tgt);
        logic [31:0] w;
        if (m_mode == M_IDLE || m_mode == M_HALTED) begin
            m_instr = NOP;
            m_valid = 1'b0;
            if (st) begin
                m_mode    = M_RUN;
                m_pc      = 32'h0;
                m_drained = 0;
            end
        end else if (br) begin
            m_mode  = M_RUN;
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (!sl) begin
            if (m_mode == M_RUN) begin
                w       = mem_word(m_pc, halt_addr);
                m_instr = w;
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                if (w == HALT) begin
                    m_mode    = M_DRAIN;
                    m_drained = 0;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end else begin
                m_instr   = NOP;
                m_valid   = 1'b0;
                m_drained = m_drained + 1;
                if (m_drained == DRAIN) m_mode = M_HALTED;
            end
        end
    endtask

    // Drive one cycle: inputs applied after negedge, expectation queued after posedge.
    task automatic cycle(input bit st, input bit sl, input bit br, input logic [31:0] tgt);
        start     = st;
        stall     = sl;
        br_taken  = br;
        br_target = tgt;
        if (!rst_n) model_reset();
        else        model_edge(st, sl, br, tgt);
        @(posedge clk);
        #1;
        exp_q.push_back(model_snap());
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_to_pc(input logic [31:0] target, input int budget);
        int n = 0;
        while (m_pc != target && n < budget) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (m_pc != target) begin
            errors++;
            $display("FAIL run_to_pc: model pc=%h never reached required %h", m_pc, target);
        end
    endtask

    task automatic run_to_mode(input int mode, input int budget);
        int n = 0;
        while (m_mode != mode && n < budget) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (m_mode != mode) begin
            errors++;
            $display("FAIL run_to_mode: model mode=%0d, required %0d", m_mode, mode);
        end
    endtask

    // Reset pulled mid-cycle; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_addr, if_instr, if_pc, if_valid, busy, done} !==
            {32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: addr=%h instr=%h pc=%h v=%b busy=%b done=%b", imem_addr, if_instr,
                     if_pc, if_valid, busy, done);
        end
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
    endtask

    // Monitor: every negedge, compare the DUT against the oldest expectation.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({imem_addr, if_instr, if_pc, if_valid, busy, done} !== e) begin
                    errors++;
                    $display("FAIL cycle_out @%0t: got addr=%h instr=%h pc=%h v=%b busy=%b done=%b, exp addr=%h instr=%h pc=%h v=%b busy=%b done=%b",
                             $time, imem_addr, if_instr, if_pc, if_valid, busy, done,
                             e.addr, e.instr, e.ifpc, e.valid, e.busy, e.done);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        halt_addr = 32'h90;
        model_reset();
        @(negedge clk);
        #1;
        idle_cycles(2);
        rst_n = 1'b1;

        // Idle ignores stall/branch
        cycle(1'b0, 1'b1, 1'b1, 32'h44);
        idle_cycles(1);

        // Straight-line fetch, stall at 0x10, branch+stall at 0x20
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_to_pc(32'h10, 20);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        run_to_pc(32'h20, 20);
        cycle(1'b0, 1'b1, 1'b1, 32'h86);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);   // start ignored in RUN

        // Halt at 0x90, drain, done; halted ignores branch/stall
        run_to_mode(M_HALTED, 30);
        idle_cycles(2);
        cycle(1'b0, 1'b1, 1'b1, 32'h20);

        // Restart; halt at 0x18 then cancel drain with a branch on its 2nd cycle
        halt_addr = 32'h18;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_to_mode(M_DRAIN, 20);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);   // stall holds the drain count
        idle_cycles(1);
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        halt_addr = 32'h1;
        idle_cycles(DRAIN + 2);

        // Mid-run async reset at 0x2C; stays idle until start
        cycle(1'b0, 1'b0, 1'b1, 32'h20);
        run_to_pc(32'h2C, 20);
        async_reset();
        cycle(1'b0, 1'b1, 1'b1, 32'h80);
        idle_cycles(2);

        // PC wrap from 0xFFFFFFF8
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
        idle_cycles(4);

        // Randomized traffic with a reachable halt
        halt_addr = 32'h30;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 32'h60));
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, tgt);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
